// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: controller state, read owner tags
// and the byte-offset width of a 32-bit word address.
package sram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        TAG_IF = 1'b0,
        TAG_LS = 1'b1
    } owner_tag_e;

    localparam int WORD_LSB = 2;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Tracks port B reads in flight: a valid+owner shift register RD_LAT deep,
// so the response pops out exactly when the SRAM presents the data.
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_tag,
    output logic rsp_valid,
    output logic rsp_tag
);

    logic [RD_LAT:1] vld_q;
    logic [RD_LAT:1] tag_q;
    logic [RD_LAT:0] vld_pipe;
    logic [RD_LAT:0] tag_pipe;

    // Stage 0 is the grant of this cycle; stage RD_LAT lines up with doutb.
    assign vld_pipe = {vld_q, push};
    assign tag_pipe = {tag_q, push_tag};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_pipe[RD_LAT-1:0];
            tag_q <= tag_pipe[RD_LAT-1:0];
        end
    end

    assign rsp_valid = vld_pipe[RD_LAT];
    assign rsp_tag   = tag_pipe[RD_LAT];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a write-port/read-port block SRAM between instruction fetch and
// load/store: waits out SRAM reset-busy, round-robins port B, routes read data.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              ls_req_valid,
    input  logic [3:0]        ls_req_we,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [31:0]       ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [31:0]       ls_rsp_data,
    output logic              sram_ena,
    output logic [3:0]        sram_wea,
    output logic [ADDR_W-1:0] sram_addra,
    output logic [31:0]       sram_dina,
    output logic              sram_enb,
    output logic [ADDR_W-1:0] sram_addrb,
    input  logic [31:0]       sram_doutb,
    input  logic              sram_rsta_busy,
    input  logic              sram_rstb_busy
);

    state_e     state;
    owner_tag_e rr_ptr;

    logic              sram_idle;
    logic              run;
    logic              ls_is_wr;
    logic              ls_wr;
    logic              ls_rd_cand;
    logic              if_cand;
    logic              collision;
    logic              contested;
    logic              grant_if;
    logic              grant_ls;
    logic [ADDR_W-1:0] if_word_addr;
    logic [ADDR_W-1:0] ls_word_addr;
    logic              pipe_vld;
    logic              pipe_tag;
    logic [31:0]       if_data_q;
    logic [31:0]       ls_data_q;
    logic              unused_addr_lsb;

    assign sram_idle = !sram_rsta_busy && !sram_rstb_busy;

    // The INIT cycle that first sees the SRAM idle already serves requests,
    // so the first accept lands on the very cycle busy drops.
    assign run = rst_n && ((state == ST_RUN) || sram_idle);

    assign if_word_addr    = {if_req_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
    assign ls_word_addr    = {ls_req_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
    assign unused_addr_lsb = ^{if_req_addr[WORD_LSB-1:0], ls_req_addr[WORD_LSB-1:0]};

    assign ls_is_wr   = (ls_req_we != 4'd0);
    assign ls_wr      = run && ls_req_valid && ls_is_wr;
    assign ls_rd_cand = run && ls_req_valid && !ls_is_wr;

    // A same-word write wins; the fetch retries next cycle and sees new data.
    assign collision = ls_wr && if_req_valid &&
                       (if_req_addr[ADDR_W-1:WORD_LSB] == ls_req_addr[ADDR_W-1:WORD_LSB]);
    assign if_cand   = run && if_req_valid && !collision;

    assign contested = if_cand && ls_rd_cand;
    assign grant_if  = if_cand && (!ls_rd_cand || (rr_ptr == TAG_IF));
    assign grant_ls  = ls_rd_cand && (!if_cand || (rr_ptr == TAG_LS));

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls || (run && ls_is_wr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_INIT;
            rr_ptr <= TAG_IF;
        end else begin
            case (state)
                ST_INIT: if (sram_idle) state <= ST_RUN;
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_INIT;
            endcase
            if (contested) begin
                rr_ptr <= (rr_ptr == TAG_IF) ? TAG_LS : TAG_IF;
            end
        end
    end

    always_comb begin
        sram_ena   = ls_wr;
        sram_wea   = 4'd0;
        sram_addra = '0;
        sram_dina  = 32'd0;
        if (ls_wr) begin
            sram_wea   = ls_req_we;
            sram_addra = ls_word_addr;
            sram_dina  = ls_req_wdata;
        end
    end

    always_comb begin
        sram_enb   = grant_if || grant_ls;
        sram_addrb = '0;
        if (grant_ls) begin
            sram_addrb = ls_word_addr;
        end else if (grant_if) begin
            sram_addrb = if_word_addr;
        end
    end

    sram_rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (sram_enb),
        .push_tag (grant_ls ? TAG_LS : TAG_IF),
        .rsp_valid(pipe_vld),
        .rsp_tag  (pipe_tag)
    );

    // Gating by rst_n drops a read that completes during a reset cycle.
    assign if_rsp_valid = rst_n && pipe_vld && (pipe_tag == TAG_IF);
    assign ls_rsp_valid = rst_n && pipe_vld && (pipe_tag == TAG_LS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_data_q <= 32'd0;
            ls_data_q <= 32'd0;
        end else begin
            if (if_rsp_valid) if_data_q <= sram_doutb;
            if (ls_rsp_valid) ls_data_q <= sram_doutb;
        end
    end

    assign if_rsp_data = if_rsp_valid ? sram_doutb : if_data_q;
    assign ls_rsp_data = ls_rsp_valid ? sram_doutb : ls_data_q;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the dual-port block SRAM (port A write-only, port B read-only, byte write enables, 32-bit data) between two requesters: instruction fetch (IF, read-only) and load/store (LS, read or write).
- Waits out SRAM reset-busy after reset.
- Arbitrates port B reads round-robin.
- Resolves same-cycle write/read address collisions.
- Returns read data to the owning requester after a fixed latency.

Parameters:
- ADDR_W, 32, byte-address width on requester and SRAM sides.
- RD_LAT, 1, SRAM port B read latency in cycles (1 or 2).

Ports:
- clk  in  1  single clock, drives SRAM clka/clkb externally
- rst_n  in  1  synchronous active-low reset
- if_req_valid  in  1  IF read request
- if_req_addr  in  ADDR_W  IF byte address
- if_req_ready  out  1  IF request accepted this cycle
- if_rsp_valid  out  1  IF read data valid
- if_rsp_data  out  32  IF read data
- ls_req_valid  in  1  LS request
- ls_req_we  in  4  byte enables; nonzero = write, zero = read
- ls_req_addr  in  ADDR_W  LS byte address
- ls_req_wdata  in  32  LS write data
- ls_req_ready  out  1  LS request accepted this cycle
- ls_rsp_valid  out  1  LS read data valid (reads only)
- ls_rsp_data  out  32  LS read data
- sram_ena  out  1  port A enable
- sram_wea  out  4  port A byte write enable
- sram_addra  out  ADDR_W  port A address
- sram_dina  out  32  port A write data
- sram_enb  out  1  port B enable
- sram_addrb  out  ADDR_W  port B address
- sram_doutb  in  32  port B read data
- sram_rsta_busy  in  1  port A reset busy
- sram_rstb_busy  in  1  port B reset busy

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values:
  - All outputs 0; both ready signals 0.
  - State INIT; RR pointer = IF; in-flight tag pipeline cleared.
- Reset asserted mid-operation: in-flight reads are dropped; no rsp_valid is produced for them after reset.
- States:
  - INIT: ready = 0, enables = 0. Go to RUN on the first cycle after reset release in which sram_rsta_busy = 0 and sram_rstb_busy = 0.
  - RUN: normal operation. There is no return to INIT except via reset.
- Address handling: SRAM address = request address with bits [1:0] forced to 0.
- Handshakes:
  - A request transfers when valid && ready in the same cycle.
  - ready is combinational from the valid inputs and the arbiter state.
  - Requesters must hold valid/addr/data until accepted.
- LS write:
  - In RUN, ls_req_ready = 1 whenever ls_req_we != 0.
  - On transfer: sram_ena = 1, sram_wea = ls_req_we, addra/dina driven in that cycle.
  - No response is generated.
- Port B reads:
  - Candidates are the IF read and the LS read (ls_req_we == 0).
  - If both are valid, the grant goes to the RR pointer owner; the pointer flips to the other requester after each contested grant.
  - An uncontested request is granted immediately and the pointer is unchanged.
  - Granted cycle: sram_enb = 1, addrb = granted address, owner tag pushed into an RD_LAT-deep shift register.
- Collision:
  - An LS write and an IF read to the same word (addr[ADDR_W-1:2]) in the same cycle: the write wins, and if_req_ready = 0 that cycle.
  - The IF read is accepted the next cycle and returns post-write data.
- Read latency: exactly RD_LAT cycles after acceptance, rsp_valid = 1 for one cycle on the tagged owner, with rsp_data = sram_doutb.
- rsp_data holds its last value when rsp_valid = 0.
- Throughput: one port B read and one port A write per cycle; back-to-back reads at full rate with no bubbles.
- Responses have no backpressure; requesters must always sink rsp_valid.
- Writes and reads have no ordering beyond the SRAM itself: a write at cycle N is visible to a read accepted at N+1.

Decomposition:
- Package sram_arb_pkg:
  - State enum (INIT, RUN).
  - Owner tag enum (TAG_IF, TAG_LS).
  - WORD_LSB = 2.
- One sub-module, sram_rd_tag_pipe: RD_LAT-deep valid+tag shift register with synchronous clear; produces rsp_valid/owner.

Test Plan:
- Reset with sram_rstb_busy held high 5 cycles after rst_n release, if_req_valid = 1 throughout -> if_req_ready = 0 for those 5 cycles; the first accept occurs the cycle busy drops; if_rsp_valid follows RD_LAT = 1 cycle later.
- LS write addr 0x40, we = 0xF, data 0xDEADBEEF; next cycle IF read 0x40 -> sram_wea = 0xF on the write cycle; if_rsp_data = 0xDEADBEEF one cycle after the IF accept.
- Same cycle: LS write 0x80 = 0x12345678 and IF read 0x82 -> if_req_ready = 0 that cycle; IF accepted the next cycle; if_rsp_data = 0x12345678.
- IF and LS reads both valid for 4 cycles, RR pointer at IF -> grants IF, LS, IF, LS; each rsp_valid arrives on the correct port RD_LAT later.
- RD_LAT = 2, 3 back-to-back IF reads of 0x0/0x4/0x8 -> three consecutive if_rsp_valid pulses with matching data and no gaps.
- rst_n asserted the cycle after an LS read is accepted -> ls_rsp_valid is never asserted for it; all outputs return to 0; state returns to INIT.
